// File: rtl/heap_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// heap_cmd_sequencer : queues push/pop requests and issues them one at a time
// to a heap unit, tracking occupancy, result tags and pop timeouts.
// Revision: 1.0
// ============================================================================
module heap_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int HEAP_DEPTH = 16,
   parameter int TIMEOUT    = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_v,
   output logic                        req_ready,
   input  logic [1:0]                  req_op,
   input  logic [31:0]                 req_data,
   output logic                        heap_in_v,
   output logic [2:0]                  heap_vrd1,
   output logic [31:0]                 heap_in_data,
   output logic [4:0]                  heap_rd,
   input  logic                        heap_out_v,
   input  logic [31:0]                 heap_out_data,
   input  logic [4:0]                  heap_out_rd,
   output logic                        rsp_v,
   input  logic                        rsp_ready,
   output logic [31:0]                 rsp_data,
   output logic [1:0]                  rsp_status,
   output logic [$clog2(HEAP_DEPTH):0] occupancy
);
   localparam int C_AW = $clog2(FIFO_DEPTH);
   localparam int C_OW = $clog2(HEAP_DEPTH) + 1;
   localparam int C_TW = $clog2(TIMEOUT) + 1;

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_issue = 2'd1;
   localparam logic [1:0] c_st_wait  = 2'd2;
   localparam logic [1:0] c_st_resp  = 2'd3;

   localparam logic [1:0] c_op_push  = 2'b01;
   localparam logic [1:0] c_op_pop   = 2'b10;
   localparam logic [1:0] c_rs_ok    = 2'b00;
   localparam logic [1:0] c_rs_full  = 2'b01;
   localparam logic [1:0] c_rs_empty = 2'b10;
   localparam logic [1:0] c_rs_err   = 2'b11;
   localparam logic [2:0] c_vrd_push = 3'd1;
   localparam logic [2:0] c_vrd_pop  = 3'd2;

   localparam logic [C_AW:0]   c_fifo_full = (C_AW + 1)'(FIFO_DEPTH);
   localparam logic [C_AW-1:0] c_ptr_one   = C_AW'(1);
   localparam logic [C_AW:0]   c_cnt_one   = (C_AW + 1)'(1);
   localparam logic [C_OW-1:0] c_heap_max  = C_OW'(HEAP_DEPTH);
   localparam logic [C_OW-1:0] c_occ_one   = C_OW'(1);
   localparam logic [C_TW-1:0] c_tmr_last  = C_TW'(TIMEOUT - 1);
   localparam logic [C_TW-1:0] c_tmr_one   = C_TW'(1);
   localparam logic [4:0]      c_tag_one   = 5'd1;

   logic [1:0]      state_q, state_d;
   logic [C_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [C_AW:0]   cnt_q, cnt_d;
   logic [33:0]     fifo_mem_q [FIFO_DEPTH];
   logic [33:0]     fifo_mem_d [FIFO_DEPTH];
   logic [C_OW-1:0] occ_q, occ_d;
   logic [4:0]      tag_q, tag_d, issued_tag_q, issued_tag_d;
   logic [C_TW-1:0] timer_q, timer_d;
   logic [31:0]     rsp_data_q, rsp_data_d;
   logic [1:0]      rsp_status_q, rsp_status_d;

   logic        w_fifo_full, w_fifo_empty, w_accept, w_deq;
   logic        w_can_push, w_can_pop, w_strobe, w_match, w_expired;
   logic [1:0]  w_head_op;
   logic [31:0] w_head_data;

   assign w_fifo_full  = (cnt_q == c_fifo_full);
   assign w_fifo_empty = (cnt_q == '0);
   // Ready follows the reset pin so it is low for the whole reset window.
   assign req_ready    = reset & ~w_fifo_full;
   assign w_accept     = req_v & req_ready;
   assign w_deq        = (state_q == c_st_issue) & ~w_fifo_empty;

   assign {w_head_op, w_head_data} = fifo_mem_q[rd_ptr_q];
   assign w_can_push = (w_head_op == c_op_push) && (occ_q < c_heap_max);
   assign w_can_pop  = (w_head_op == c_op_pop) && (occ_q != '0);
   assign w_strobe   = (state_q == c_st_issue) && (w_can_push || w_can_pop);
   assign w_match    = heap_out_v && (heap_out_rd == issued_tag_q);
   assign w_expired  = (timer_q == c_tmr_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= c_st_idle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_idle:  if (!w_fifo_empty) state_d = c_st_issue;
         c_st_issue: state_d = w_can_pop ? c_st_wait : c_st_resp;
         c_st_wait:  if (w_match || w_expired) state_d = c_st_resp;
         default:    if (rsp_ready) state_d = w_fifo_empty ? c_st_idle : c_st_issue;
      endcase
   end

   always_comb begin
      heap_in_v    = w_strobe;
      heap_vrd1    = 3'd0;
      heap_in_data = '0;
      if (w_strobe && w_can_push) begin
         heap_vrd1    = c_vrd_push;
         heap_in_data = w_head_data;
      end else if (w_strobe) begin
         heap_vrd1 = c_vrd_pop;
      end
      rsp_v = (state_q == c_st_resp);
   end

   assign heap_rd    = tag_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_status = rsp_status_q;
   assign occupancy  = occ_q;

   always_comb begin
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (w_accept) begin
         fifo_mem_d[wr_ptr_q] = {req_op, req_data};
         wr_ptr_d             = wr_ptr_q + c_ptr_one;
      end
      if (w_deq) rd_ptr_d = rd_ptr_q + c_ptr_one;
      case ({w_accept, w_deq})
         2'b10:   cnt_d = cnt_q + c_cnt_one;
         2'b01:   cnt_d = cnt_q - c_cnt_one;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      occ_d        = occ_q;
      tag_d        = tag_q;
      issued_tag_d = issued_tag_q;
      timer_d      = timer_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      case (state_q)
         c_st_issue: begin
            timer_d    = '0;
            rsp_data_d = '0;
            if (w_strobe) begin
               tag_d        = tag_q + c_tag_one;
               issued_tag_d = tag_q;
            end
            if (w_can_push) begin
               occ_d        = occ_q + c_occ_one;
               rsp_status_d = c_rs_ok;
            end else if (w_can_pop) begin
               occ_d        = occ_q - c_occ_one;
               rsp_status_d = c_rs_ok;
            end else if (w_head_op == c_op_push) begin
               rsp_status_d = c_rs_full;
            end else if (w_head_op == c_op_pop) begin
               rsp_status_d = c_rs_empty;
            end else begin
               rsp_status_d = c_rs_err;
            end
         end
         c_st_wait: begin
            // A timed-out pop keeps its occupancy decrement; the heap did pop.
            if (w_match) begin
               rsp_data_d   = heap_out_data;
               rsp_status_d = c_rs_ok;
            end else if (w_expired) begin
               rsp_data_d   = '0;
               rsp_status_d = c_rs_err;
            end else begin
               timer_d = timer_q + c_tmr_one;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
         occ_q        <= '0;
         tag_q        <= '0;
         issued_tag_q <= '0;
         timer_q      <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         fifo_mem_q   <= fifo_mem_d;
         occ_q        <= occ_d;
         tag_q        <= tag_d;
         issued_tag_q <= issued_tag_d;
         timer_q      <= timer_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
      end
   end
endmodule
`default_nettype wire

// File: doc/heap_cmd_sequencer.md
HEAP_CMD_SEQUENCER -- requirements
Module: heap_cmd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: request FIFO entries, power of two, at least 2.
REQ-002 SHALL have parameter HEAP_DEPTH, default 16: heap element capacity tracked locally.
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum cycles to wait for a pop result.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
REQ-005 SHALL have these requester ports:
- req_v  in  1  request valid.
- req_ready  out  1  request accepted when req_v and req_ready are both high.
- req_op  in  2  01 push, 10 pop; 00 and 11 illegal.
- req_data  in  32  push key.
REQ-006 SHALL have these heap-unit ports:
- heap_in_v  out  1  one-cycle command strobe.
- heap_vrd1  out  3  opcode: 1 push, 2 pop.
- heap_in_data  out  32  push key.
- heap_rd  out  5  command tag.
- heap_out_v  in  1  result valid.
- heap_out_data  in  32  popped key.
- heap_out_rd  in  5  result tag.
REQ-007 SHALL have these response ports:
- rsp_v  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  popped key, 0 otherwise.
- rsp_status  out  2  00 OK, 01 FULL, 10 EMPTY, 11 TIMEOUT/ILLEGAL.
- occupancy  out  $clog2(HEAP_DEPTH)+1  current heap count.

Function
REQ-008 SHALL buffer requests in a FIFO_DEPTH-entry FIFO; req_ready = FIFO not full; simultaneous push and pop of the FIFO when full is not allowed (req_ready low).
REQ-009 SHALL run FSM IDLE -> ISSUE -> (WAIT, pop only) -> RESP -> IDLE; leave IDLE only when the FIFO is non-empty.
REQ-010 In ISSUE, a push with occupancy < HEAP_DEPTH SHALL drive heap_in_v=1 for exactly one cycle with heap_vrd1=1, heap_in_data=req_data, increment occupancy, then go to RESP with status OK.
REQ-011 A push with occupancy == HEAP_DEPTH SHALL NOT strobe heap_in_v and SHALL go to RESP with status FULL.
REQ-012 A pop with occupancy > 0 SHALL strobe heap_in_v for one cycle with heap_vrd1=2, heap_in_data=0, decrement occupancy, then go to WAIT.
REQ-013 A pop with occupancy == 0 SHALL NOT strobe and SHALL go to RESP with status EMPTY.
REQ-014 An illegal req_op SHALL NOT strobe and SHALL go to RESP with status 11.
REQ-015 heap_rd SHALL carry a 5-bit tag that increments (wrapping 31 -> 0) on every strobe.
REQ-016 WAIT SHALL capture heap_out_data on the first heap_out_v whose heap_out_rd equals the issued tag, then go to RESP with status OK; heap_out_v with a non-matching tag SHALL be ignored.
REQ-017 WAIT SHALL exit to RESP with status TIMEOUT and rsp_data=0 after TIMEOUT cycles with no match; a late result SHALL be dropped, and occupancy SHALL NOT be restored.
REQ-018 RESP SHALL hold rsp_v=1 with stable rsp_data and rsp_status until rsp_ready; on handshake go to IDLE, or directly to ISSUE if the FIFO is non-empty.
REQ-019 SHALL keep at most one heap command outstanding; heap_in_v SHALL be 0 in all states other than ISSUE.
REQ-020 FIFO state SHALL be updated on each clock edge from that edge's accept and dequeue, including when both occur in the same cycle.

Reset
REQ-021 While reset is low, all registered state SHALL clear asynchronously: FSM=IDLE, FIFO empty, occupancy=0, tag=0, heap_in_v=0, rsp_v=0, rsp_data=0, rsp_status=00. req_ready SHALL be 0 while reset is low and 1 in the first cycle after release.
REQ-022 Reset asserted mid-WAIT or mid-RESP SHALL discard the in-flight operation; no strobe or response SHALL appear after release until a new request arrives.

Verification
REQ-023 Push 10, 20, 15, 30, 40 -> five single-cycle strobes with vrd1=1 and tags 0..4; five OK responses; occupancy=5.
REQ-024 Then pop x5, with the heap model returning 10, 15, 20, 30, 40 -> rsp_data in that order, status OK, occupancy=0.
REQ-025 Pop on an empty heap -> no strobe, status EMPTY; after 16 pushes, a 17th push -> no strobe, status FULL.
REQ-026 Pop whose result never returns -> TIMEOUT response exactly TIMEOUT cycles after WAIT entry; a stale result with an old tag is ignored on the next pop.
REQ-027 Hold rsp_ready=0 while sending 6 requests -> req_ready drops after FIFO_DEPTH entries accepted plus the one in service; no request is lost once rsp_ready is raised.
REQ-028 Assert reset during WAIT -> all outputs reach their reset values without a clock edge; the next push after release gets tag 0.
